// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-PC core: widths, opcode field layout,
// sequencer state encoding and the per-state phase decode.
package cpu_pkg;

    // Architectural widths
    localparam int PC_W = 4;
    localparam int OP_W = 32;

    // Opcode field location inside the instruction word
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    // Opcode values
    localparam logic [OPC_W-1:0] OPC_ALU  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_JMP  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

    // Fetch/execute sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } seq_state_t;

    // Per-state control bits, registered alongside the state so that the
    // outputs come straight from flops.
    typedef struct packed {
        logic imem_req;
        logic busy;
        logic halted;
        logic in_exec;
        logic in_wb;
    } phase_flags_t;

    // Control bits that hold while the sequencer sits in state s
    function automatic phase_flags_t phase_flags(input seq_state_t s);
        phase_flags_t f;
        f = '0;
        case (s)
            ST_FETCH: begin
                f.imem_req = 1'b1;
                f.busy     = 1'b1;
            end
            ST_EXEC: begin
                f.busy    = 1'b1;
                f.in_exec = 1'b1;
            end
            ST_WB: begin
                f.busy  = 1'b1;
                f.in_wb = 1'b1;
            end
            ST_HALT: f.halted = 1'b1;
            default: ;
        endcase
        return f;
    endfunction

    // Extract the opcode field from an instruction word
    function automatic logic [OPC_W-1:0] opcode_of(input logic [OP_W-1:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus: req/addr from the sequencer, ack/data back
// from the memory. Data is only meaningful in a cycle where req and ack are
// both high.
interface instr_sequencer_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [OP_W-1:0] imem_data;

    // Sequencer side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    // Memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute controller. Owns pc, the instruction register
// and the zero flag; fetches over a req/ack bus and turns the decoder's raw
// write requests into strobes that only fire in their own phase.
module instr_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    instr_sequencer_if.master   imem,
    output logic [OP_W-1:0]     op,
    output logic                zf,
    input  logic [PC_W-1:0]     dec_pc_in,
    input  logic                dec_pc_we,
    input  logic                dec_reg_we,
    input  logic                dec_mem_we,
    input  logic                alu_zf,
    output logic                reg_we,
    output logic                mem_we,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic                halted
);

    seq_state_t      state;
    seq_state_t      state_next;
    phase_flags_t    flags;
    logic            fetch_done;
    logic            fetch_is_halt;
    logic [PC_W-1:0] pc_inc;

    // A fetch completes only when our own request is acknowledged
    assign fetch_done    = flags.imem_req && imem.imem_ack;
    assign fetch_is_halt = (opcode_of(imem.imem_data) == OPC_HALT);

    // Sequential pc; the add truncates so the top address wraps to 0
    assign pc_inc = pc + PC_W'(1);

    // Next-state selection; run only matters in IDLE and at the end of WB
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_done) state_next = fetch_is_halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = run ? ST_FETCH : ST_IDLE;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // State, phase flags and architectural registers; rst overrides everything
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
            flags <= '0;
            pc    <= '0;
            op    <= '0;
            zf    <= 1'b0;
        end else begin
            state <= state_next;
            flags <= phase_flags(state_next);
            if (fetch_done) begin
                op <= imem.imem_data;
            end
            if (flags.in_wb) begin
                if (dec_reg_we) begin
                    zf <= alu_zf;
                end
                pc <= dec_pc_we ? dec_pc_in : pc_inc;
            end
        end
    end

    // The decoder holds stale requests outside EXEC/WB, so gate by phase
    assign reg_we = flags.in_wb   && dec_reg_we;
    assign mem_we = flags.in_exec && dec_mem_we;

    // pc only moves at the WB edge, so the address is stable through FETCH
    assign imem.imem_req  = flags.imem_req;
    assign imem.imem_addr = pc;
    assign busy           = flags.busy;
    assign halted         = flags.halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. The bench plays instruction
// memory and a small decoder, and tracks pc/zf/op per instruction.
module tb_instr_sequencer;
    import cpu_pkg::*;

    localparam logic [3:0] OPC_STORE = 4'h2;

    typedef struct packed {
        logic            reg_we;
        logic            mem_we;
        logic            pc_we;
        logic [PC_W-1:0] pc_in;
        logic            alu_zf;
    } dec_t;

    logic            clk;
    logic            rst;
    logic            run;
    logic [OP_W-1:0] op;
    logic            zf;
    logic [PC_W-1:0] dec_pc_in;
    logic            dec_pc_we;
    logic            dec_reg_we;
    logic            dec_mem_we;
    logic            alu_zf;
    logic            reg_we;
    logic            mem_we;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem       (bus),
        .op         (op),
        .zf         (zf),
        .dec_pc_in  (dec_pc_in),
        .dec_pc_we  (dec_pc_we),
        .dec_reg_we (dec_reg_we),
        .dec_mem_we (dec_mem_we),
        .alu_zf     (alu_zf),
        .reg_we     (reg_we),
        .mem_we     (mem_we),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    // Toy decoder: ALU writes a register (zero result from bit 21), JMP loads
    // pc from the low bits, STORE writes memory, anything else does nothing.
    function automatic dec_t tb_decode(input logic [OP_W-1:0] w);
        dec_t d;
        d.reg_we = (w[31:28] == OPC_ALU);
        d.mem_we = (w[31:28] == OPC_STORE);
        d.pc_we  = (w[31:28] == OPC_JMP);
        d.pc_in  = w[PC_W-1:0];
        d.alu_zf = w[21];
        return d;
    endfunction

    // The decoder sees the DUT's op continuously, stale values included
    dec_t cur_dec;
    assign cur_dec    = tb_decode(op);
    assign dec_reg_we = cur_dec.reg_we;
    assign dec_mem_we = cur_dec.mem_we;
    assign dec_pc_we  = cur_dec.pc_we;
    assign dec_pc_in  = cur_dec.pc_in;
    assign alu_zf     = cur_dec.alu_zf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int num_checks = 0;
    int num_errors = 0;

    // Reference state
    logic [PC_W-1:0] m_pc;
    logic            m_zf;
    logic [OP_W-1:0] m_op;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        assert (obs === exp) else begin
            num_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] p);
        return PC_W'((int'(p) + 1) % (1 << PC_W));
    endfunction

    // Run one instruction starting in its first FETCH cycle
    task automatic exec_instr(input logic [31:0] w, input int waits,
                              input bit drop_run, input string tag);
        dec_t d;
        int   t0;
        d  = tb_decode(w);
        t0 = cyc;
        check({tag, "/req"},  32'(bus.imem_req),  1);
        check({tag, "/addr"}, 32'(bus.imem_addr), 32'(m_pc));
        for (int i = 0; i < waits; i++) begin
            bus.imem_ack  = 1'b0;
            bus.imem_data = $urandom();
            step();
            check({tag, "/wait_req"},    32'(bus.imem_req),  1);
            check({tag, "/wait_addr"},   32'(bus.imem_addr), 32'(m_pc));
            check({tag, "/wait_op"},     op,                 m_op);
            check({tag, "/wait_reg_we"}, 32'(reg_we),        0);
            check({tag, "/wait_mem_we"}, 32'(mem_we),        0);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = w;
        step();
        bus.imem_ack  = 1'b0;
        bus.imem_data = $urandom();
        m_op = w;
        check({tag, "/op"}, op, m_op);
        if (w[31:28] == OPC_HALT) begin
            check({tag, "/halted"}, 32'(halted),       1);
            check({tag, "/busy"},   32'(busy),         0);
            check({tag, "/req"},    32'(bus.imem_req), 0);
            check({tag, "/reg_we"}, 32'(reg_we),       0);
            check({tag, "/mem_we"}, 32'(mem_we),       0);
            return;
        end
        // EXEC
        check({tag, "/ex_mem_we"}, 32'(mem_we),       32'(d.mem_we));
        check({tag, "/ex_reg_we"}, 32'(reg_we),       0);
        check({tag, "/ex_req"},    32'(bus.imem_req), 0);
        check({tag, "/ex_busy"},   32'(busy),         1);
        check({tag, "/ex_pc"},     32'(pc),           32'(m_pc));
        if (drop_run) run = 1'b0;
        step();
        // WB
        check({tag, "/wb_reg_we"}, 32'(reg_we), 32'(d.reg_we));
        check({tag, "/wb_mem_we"}, 32'(mem_we), 0);
        check({tag, "/wb_busy"},   32'(busy),   1);
        check({tag, "/wb_zf"},     32'(zf),     32'(m_zf));
        if (d.reg_we) m_zf = d.alu_zf;
        m_pc = d.pc_we ? d.pc_in : next_seq_pc(m_pc);
        step();
        check({tag, "/pc"}, 32'(pc), 32'(m_pc));
        check({tag, "/zf"}, 32'(zf), 32'(m_zf));
        if (drop_run) begin
            check({tag, "/idle_req"},  32'(bus.imem_req), 0);
            check({tag, "/idle_busy"}, 32'(busy),         0);
        end else begin
            check({tag, "/next_req"},  32'(bus.imem_req),  1);
            check({tag, "/next_addr"}, 32'(bus.imem_addr), 32'(m_pc));
            check({tag, "/latency"},   cyc - t0,           waits + 3);
        end
    endtask

    // Sit in IDLE for a while, then raise run and expect the next fetch
    task automatic resume(input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) begin
            step();
            check("idle/req",  32'(bus.imem_req), 0);
            check("idle/busy", 32'(busy),         0);
        end
        run = 1'b1;
        step();
        check("resume/req",  32'(bus.imem_req),  1);
        check("resume/addr", 32'(bus.imem_addr), 32'(m_pc));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        logic [3:0]  opc;
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       opc = OPC_ALU;
            1:       opc = OPC_JMP;
            2:       opc = OPC_STORE;
            default: opc = 4'($urandom_range(3, 14));
        endcase
        return {opc, r[27:0]};
    endfunction

    initial begin
        rst           = 1'b1;
        run           = 1'b1;
        bus.imem_ack  = 1'b0;
        bus.imem_data = '0;

        // Reset held two cycles with run high
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst/pc",     32'(pc),           0);
            check("rst/op",     op,                0);
            check("rst/zf",     32'(zf),           0);
            check("rst/req",    32'(bus.imem_req), 0);
            check("rst/reg_we", 32'(reg_we),       0);
            check("rst/mem_we", 32'(mem_we),       0);
            check("rst/busy",   32'(busy),         0);
            check("rst/halted", 32'(halted),       0);
        end
        m_pc = '0;
        m_zf = 1'b0;
        m_op = '0;
        rst  = 1'b0;
        check("rst_fall/req", 32'(bus.imem_req), 0);
        step();
        check("first/req",  32'(bus.imem_req),  1);
        check("first/addr", 32'(bus.imem_addr), 0);

        // Directed: ALU, jump, wait states, wrap, store
        exec_instr(32'h0120_0000, 0, 1'b0, "alu");
        check("alu/zf_set", 32'(zf), 1);
        exec_instr(32'h1000_0007, 0, 1'b0, "jmp");
        check("jmp/pc", 32'(pc), 7);
        exec_instr(32'h3000_0000, 3, 1'b0, "wait");
        exec_instr(32'h1000_000F, 0, 1'b0, "to15");
        exec_instr(32'h0000_0000, 1, 1'b0, "wrap");
        check("wrap/pc", 32'(pc), 0);
        exec_instr(32'h2000_0000, 2, 1'b0, "store");

        // Drop run during EXEC
        exec_instr(32'h0020_0000, 0, 1'b1, "drop");
        resume(3);

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            int          waits;
            bit          drop;
            w     = rand_word();
            waits = $urandom_range(0, 3);
            drop  = ($urandom_range(0, 5) == 0);
            exec_instr(w, waits, drop, "rand");
            if (drop) resume($urandom_range(0, 2));
        end

        // Reset in the middle of a stalled fetch
        bus.imem_ack = 1'b0;
        step();
        check("midrst/req_before", 32'(bus.imem_req), 1);
        rst = 1'b1;
        step();
        check("midrst/req",  32'(bus.imem_req), 0);
        check("midrst/pc",   32'(pc),           0);
        check("midrst/op",   op,                0);
        check("midrst/zf",   32'(zf),           0);
        check("midrst/busy", 32'(busy),         0);
        rst  = 1'b0;
        m_pc = '0;
        m_zf = 1'b0;
        m_op = '0;
        step();
        check("midrst/refetch", 32'(bus.imem_req), 1);

        // Halt, then toggle run without effect, then reset out
        exec_instr(32'h0000_0000, 0, 1'b0, "pre_halt");
        exec_instr(32'hF000_0000, 1, 1'b0, "halt");
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            step();
            check("halt/halted", 32'(halted),       1);
            check("halt/req",    32'(bus.imem_req), 0);
            check("halt/busy",   32'(busy),         0);
            check("halt/pc",     32'(pc),           32'(m_pc));
            check("halt/reg_we", 32'(reg_we),       0);
            check("halt/mem_we", 32'(mem_we),       0);
        end
        rst = 1'b1;
        step();
        check("unhalt/halted", 32'(halted), 0);
        check("unhalt/pc",     32'(pc),     0);
        check("unhalt/op",     op,          0);
        rst = 1'b0;
        run = 1'b0;
        step();
        check("unhalt/idle_req",  32'(bus.imem_req), 0);
        check("unhalt/idle_busy", 32'(busy),         0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/execute controller for the 4-bit-PC core. It owns the PC, the instruction register and the zero-flag register. It fetches a 32-bit word from instruction memory with a req/ack handshake and presents it to the combinational instruction decoder. It then qualifies the decoder's pc_we/reg_we/mem_we into single-cycle strobes so that register-file, data-memory and PC writes occur only in the correct phase.

Parameters:
PC_W, 4, program counter width; PC wraps modulo 2^PC_W
OP_W, 32, instruction word width
OPC_HALT, 4'hF, value of op[31:28] that halts the core

Ports:
clk  input  1  system clock; everything is rising-edge
rst  input  1  synchronous, active-high reset
run  input  1  level; start/continue executing instructions
imem_req  output  1  fetch request, held until ack
imem_addr  output  PC_W  fetch address; equals pc while imem_req is high
imem_ack  input  1  fetch data valid this cycle
imem_data  input  OP_W  fetched instruction word
op  output  OP_W  instruction register, drives the decoder
zf  output  1  latched zero flag, drives the decoder
dec_pc_in  input  PC_W  jump target from the decoder
dec_pc_we  input  1  decoder jump request
dec_reg_we  input  1  decoder register-write request
dec_mem_we  input  1  decoder memory-write request
alu_zf  input  1  ALU zero result for the current instruction
reg_we  output  1  qualified register-file write strobe
mem_we  output  1  qualified data-memory write strobe
pc  output  PC_W  current program counter
busy  output  1  high in FETCH, EXEC and WB
halted  output  1  high in HALT

Behaviour:
- States: IDLE, FETCH, EXEC, WB, HALT.
- Reset values: state=IDLE, pc=0, op=0, zf=0. Every output deasserts: imem_req, reg_we, mem_we, busy, halted all 0.
- rst wins over all other inputs in every state. Asserting it mid-fetch abandons the fetch; imem_req is 0 in the cycle after the reset edge.
- IDLE: if run=1, go to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - imem_data is sampled only when imem_req&imem_ack.
  - On ack, op<=imem_data. If imem_data[31:28]==OPC_HALT, go to HALT; otherwise go to EXEC.
  - run is ignored inside FETCH.
- EXEC (exactly 1 cycle):
  - The decoder evaluates op combinationally.
  - mem_we = dec_mem_we in this cycle only.
  - Go to WB.
- WB (exactly 1 cycle):
  - reg_we = dec_reg_we in this cycle only.
  - If dec_reg_we=1, zf<=alu_zf at the WB edge; otherwise zf holds. zf is therefore stable throughout EXEC/WB for any branch decode.
  - pc<=dec_pc_in if dec_pc_we=1; otherwise pc<=pc+1, truncated to PC_W bits (2^PC_W-1 wraps to 0).
  - Next state: FETCH if run=1, else IDLE. Dropping run therefore always completes the current instruction.
- HALT: halted=1, busy=0, no strobes. run is ignored; only rst exits.
- Strobes (reg_we, mem_we, imem_req) are decoded from the state register plus dec_* inputs.
  - They are never asserted outside their designated state.
  - dec_* inputs are don't-care outside EXEC/WB. The decoder holds stale values for unhandled opcodes, so this masking is mandatory.
- Latency: 3 cycles per instruction with zero-wait memory (FETCH with ack in the same cycle, EXEC, WB). Each wait cycle adds 1.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum;
  - PC_W, OP_W, OPC_HALT;
  - opcode field bounds [31:28];
  - the opcode constants OPC_ALU=0 and OPC_JMP=1.
- No sub-module. The PC incrementer and next-state logic stay inline.

Test Plan:
1. Reset: hold rst 2 cycles with run=1 -> pc=0, op=0, zf=0; imem_req, reg_we, mem_we, busy, halted all 0. The first imem_req appears the cycle after rst falls.
2. ALU op: imem[0]=32'h0120_0000, zero-wait ack, decoder gives dec_reg_we=1, alu_zf=1:
   - reg_we pulses exactly 1 cycle, in WB (cycle 3);
   - zf=1 afterwards; pc 0->1; next imem_addr=1.
3. Jump: imem[1]=32'h1000_0007, dec_pc_we=1, dec_pc_in=7 -> reg_we=0, mem_we=0, pc=7 after WB, next imem_addr=7.
4. Wait states: ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles, op unchanged until the ack edge, no strobes. Instruction latency is 6 cycles.
5. Wrap and run drop:
   - pc=15 with a non-jump instruction -> pc=0.
   - Drop run during EXEC -> WB still completes, then IDLE; imem_req stays 0 until run returns.
6. Halt: fetch 32'hF000_0000 -> halted=1, busy=0, imem_req=0, no strobes. Toggling run has no effect; rst returns to IDLE with pc=0.
